// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types for the RV32E instruction fetch path: the fetch-queue entry
// layout, the sequencer state encoding and the NOP used to fill fault entries.
package instr_fetch_ctrl_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int FAULT_W = 1;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] I_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [FAULT_W-1:0] fault;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush and same-cycle push/pop.
// A push into a full queue is accepted only when the head is popped that cycle.
module instr_fetch_ctrl_fetch_queue
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the top gates every head field with valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns fetch_pc, addresses the program ROM, checks fetch
// addresses for faults and feeds {pc, instr, fault} to decode via the queue.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ROM_WORDS   = 513,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    output logic        halted
);

    localparam int          QCW       = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

    fetch_state_t  state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   word_idx;
    logic [QCW-1:0] q_count;
    fetch_entry_t  push_entry, head;
    logic          q_empty, q_full, deq, fetch, addr_fault, fetch_fault;

    assign word_idx    = {2'b00, fetch_pc[31:2]};
    assign rom_addr    = word_idx;
    assign addr_fault  = (fetch_pc[1:0] != 2'b00) || (word_idx >= ROM_LIMIT);

    assign q_empty     = (q_count == '0);
    assign q_full      = (q_count == QCW'(QUEUE_DEPTH));
    assign deq         = !q_empty && instr_ready;
    // Redirect wins the edge; a full queue still takes a new entry when the head leaves.
    assign fetch       = enable && (state != HALT) && !redirect_valid && (!q_full || deq);
    assign fetch_fault = fetch && addr_fault;

    always_comb begin
        push_entry.pc    = fetch_pc;
        push_entry.instr = addr_fault ? I_NOP : rom_data;
        push_entry.fault = addr_fault;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc;
            state_nxt    = enable ? RUN : IDLE;
        end else begin
            // A faulting fetch leaves fetch_pc on the offending address.
            if (fetch && !addr_fault) fetch_pc_nxt = fetch_pc + 32'd4;
            case (state)
                IDLE, RUN: state_nxt = fetch_fault ? HALT : (enable ? RUN : IDLE);
                HALT:      state_nxt = HALT;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    instr_fetch_ctrl_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (fetch),
        .push_entry (push_entry),
        .pop        (deq),
        .head       (head),
        .count      (q_count)
    );

    assign instr_valid = !q_empty;
    assign instr_data  = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;
    assign instr_fault = instr_valid && head.fault[0];
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed plus randomized bench for instr_fetch_ctrl against a queue-based
// model of the fetch rules, with a ROM image held in the bench.
module tb_instr_fetch_ctrl;

    localparam int          RW  = 513;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        halted;

    logic [31:0] rom [0:RW-1];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_pc;
    logic        m_halt;
    exp_t        mq[$];

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < 32'(RW)) ? rom[rom_addr[9:0]] : 32'hDEAD_BEEF;

    instr_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .ROM_WORDS   (RW),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
        chk("rst_data",     instr_data,           32'd0);
        chk("rst_pc",       instr_pc,             32'd0);
        chk("rst_fault",    {31'b0, instr_fault}, 32'd0);
        chk("rst_halted",   {31'b0, halted},      32'd0);
        chk("rst_rom_addr", rom_addr,             32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_halt = 1'b0;
    endtask

    task automatic check_outputs();
        chk("valid", {31'b0, instr_valid}, {31'b0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            chk("head_pc",    instr_pc,             mq[0].pc);
            chk("head_data",  instr_data,           mq[0].instr);
            chk("head_fault", {31'b0, instr_fault}, {31'b0, mq[0].fault});
        end
        chk("halted",   {31'b0, halted}, {31'b0, m_halt});
        chk("rom_addr", rom_addr,        m_pc >> 2);
    endtask

    // One clock of the fetch rules, applied to the model state.
    task automatic model_step(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        int idx;
        if (rv) begin
            mq.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (en && !m_halt && mq.size() < 2) begin
                idx = int'(m_pc >> 2);
                if (m_pc[1:0] != 2'b00 || (m_pc >> 2) >= 32'(RW)) begin
                    mq.push_back('{m_pc, NOP, 1'b1});
                    m_halt = 1'b1;
                end else begin
                    mq.push_back('{m_pc, rom[idx], 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic cyc(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        enable         = en;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check_outputs();
        model_step(en, rdy, rv, rpc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        r_en, r_rdy, r_rv;
        logic [31:0] r_pc;

        rst_n          = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < RW; i++) rom[i] = $urandom;
        rom[0] = 32'h0010_0093;
        rom[1] = 32'h0010_8093;
        rom[2] = 32'h0010_8093;
        model_reset();

        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // first enable edge, then stall decode
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_pc",    instr_pc,             32'h0);
        chk("first_data",  instr_data,           32'h0010_0093);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_rom_addr", rom_addr, 32'd2);
        chk("stall_head_pc",  instr_pc, 32'h0);

        // release once: queue now holds 0x4, 0x8; redirect with decode stalled
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("pre_redir_pc", instr_pc, 32'h4);
        cyc(1'b1, 1'b0, 1'b1, 32'h10);
        chk("redir_flush_valid", {31'b0, instr_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_pc",   instr_pc,   32'h10);
        chk("redir_data", instr_data, rom[4]);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_en  = ($urandom_range(0, 7) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_pc  = 32'($urandom_range(500, 515)) << 2;
            if ($urandom_range(0, 3) == 0) r_pc = 32'($urandom_range(0, 20)) << 2;
            if ($urandom_range(0, 7) == 0) r_pc = r_pc | 32'd2;
            cyc(r_en, r_rdy, r_rv, r_pc);
        end

        // misaligned fetch target
        cyc(1'b1, 1'b0, 1'b1, 32'h802);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("mis_pc",     instr_pc,             32'h802);
        chk("mis_data",   instr_data,           NOP);
        chk("mis_fault",  {31'b0, instr_fault}, 32'd1);
        chk("mis_halted", {31'b0, halted},      32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_drained", {31'b0, instr_valid}, 32'd0);
        chk("mis_still_halted", {31'b0, halted}, 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 32'h0);
        chk("resume_halted", {31'b0, halted}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("resume_pc", instr_pc, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        // last ROM word then out-of-range
        cyc(1'b1, 1'b0, 1'b1, 32'h800);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("end_pc",    instr_pc,             32'h800);
        chk("end_data",  instr_data,           rom[512]);
        chk("end_fault", {31'b0, instr_fault}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("oor_halted", {31'b0, halted}, 32'd1);
        chk("oor_pc",     instr_pc,        32'h804);
        chk("oor_fault",  {31'b0, instr_fault}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        // fill the queue, then reset asynchronously mid-cycle
        cyc(1'b1, 1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_head_pc", instr_pc, 32'h40);
        #2;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_rst_pc", instr_pc, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Instruction fetch sequencer for the RV32E core's program ROM. Owns the fetch PC and drives the ROM word address. Captures the ROM's combinational read data into a small prefetch queue and presents {pc, instr} to decode over a valid/ready handshake. Handles redirects (branch/jump/trap) by flushing the queue, and faults on out-of-range or misaligned fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
ROM_WORDS, 513, number of 32-bit words in the program ROM (valid word index 0..ROM_WORDS-1)
QUEUE_DEPTH, 2, prefetch queue entries (fixed at 2 for this revision)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  fetch enable from core control
redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc
redirect_pc  in  32  byte address of the new fetch target
rom_addr  out  32  ROM word index = fetch_pc >> 2 (combinational from fetch_pc)
rom_data  in  32  ROM read data, combinational from rom_addr
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head this cycle
instr_data  out  32  head instruction word
instr_pc  out  32  head byte PC
instr_fault  out  1  head is a fetch-fault entry
halted  out  1  high in HALT state

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC; queue empty; state=IDLE; instr_valid=0, instr_data=0, instr_pc=0, instr_fault=0, halted=0; rom_addr=RESET_PC>>2.
- FSM states: IDLE, RUN, HALT. IDLE->RUN at edge with enable=1; RUN->IDLE at edge with enable=0 (queue contents retained, fetch_pc held); RUN->HALT when a fault entry is enqueued; HALT->RUN (enable=1) or HALT->IDLE (enable=0) only on redirect_valid; reset from any state -> IDLE.
- Fetch condition per edge: enable=1, state!=HALT, redirect_valid=0, and queue has space (not full, or full with head dequeued this cycle).
- On fetch: enqueue {fetch_pc, rom_data, fault=0}; fetch_pc += 4.
- Fault check on fetch_pc: fetch_pc[1:0]!=0 or (fetch_pc>>2) >= ROM_WORDS -> enqueue {fetch_pc, I_NOP, fault=1}; fetch_pc unchanged; state -> HALT.
- Latency: first instr_valid rises the cycle after the first edge with enable=1; sustained throughput 1 instr/cycle while instr_ready=1.
- Dequeue: at edge where instr_valid && instr_ready. instr_data/instr_pc/instr_fault stable while instr_valid && !instr_ready.
- Full queue with simultaneous dequeue and fetch: both take effect; count stays 2.
- Redirect has top priority: at that edge queue flushed (a same-cycle handshake still counts as consumed), fetch_pc <= redirect_pc, no enqueue; instr_valid=0 the following cycle; the next fetch reads redirect_pc.
- Redirect while enable=0: fetch_pc updated, queue flushed, state IDLE.
- Fault entries are dequeued like normal entries; no further fetch until redirect.
- fetch_pc increment is modulo 2^32; reaching the end of ROM range faults before any wrap matters.

Decomposition:
- Shared package/include (alongside the instruction defines): I_NOP constant, FSM state encodings (IDLE/RUN/HALT), fetch-entry field widths (pc 32, instr 32, fault 1).
- One sub-module: fetch_queue - 2-entry synchronous FIFO with flush, simultaneous push/pop, count output; instr_fetch_ctrl holds the FSM, fetch_pc and fault check.

Test Plan:
- Reset, enable=1, instr_ready=1, ROM[0..2]=ADDI x1 sequence -> instr_valid one cycle after enable; pcs 0x0,0x4,0x8 carry ROM[0],ROM[1],ROM[2]; instr_fault=0.
- instr_ready=0 for 5 cycles after the first valid -> queue holds pc 0x0 and 0x4, rom_addr holds 2, head stays pc=0x0; on release pcs 0x0,0x4,0x8 each appear exactly once.
- Redirect to 0x10 while queue holds 0x4,0x8 -> instr_valid=0 next cycle; next valid pc=0x10 with ROM[4]; 0x4 and 0x8 are never presented.
- Redirect to 0x802 -> single entry pc=0x802, instr_data=I_NOP, instr_fault=1; halted=1; no further entries; redirect to 0x0 -> halted=0, fetch resumes at pc 0x0.
- Redirect to 0x800 (ROM_WORDS=513) -> valid entry pc=0x800 with ROM[512], then fault entry pc=0x804; halted=1.
- rst_n pulsed low mid-stream with queue full -> outputs take reset values immediately without a clock; after release with enable=1, fetch restarts at RESET_PC.
